// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter sequencing controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 2;
    localparam int DEF_PASS_W = 8;

endpackage

// File: rtl/counter_ctrl_if.sv
// Host-side command/status bundle for counter_ctrl.
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PASS_W = DEF_PASS_W
);
    logic              start;
    logic [WIDTH-1:0]  limit;
    logic              reload;
    logic              pause;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] passes;

    modport master (
        output start, limit, reload, pause, abort,
        input  count, busy, done, passes
    );

    modport slave (
        input  start, limit, reload, pause, abort,
        output count, busy, done, passes
    );
endinterface

// File: rtl/counter_ctrl_core.sv
// Plain up-counter register; clear has priority over enable.
module counter_core #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/abort/reload sequencing around counter_core, with a saturating pass count.
//   state | meaning
//   IDLE  | no run active, count held at 0
//   RUN   | counting toward limit_q
//   HOLD  | paused, count frozen
//   DONE  | single-shot run finished, count holds limit_q
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PASS_W = DEF_PASS_W
) (
    input  logic         clk,
    input  logic         reset,
    counter_ctrl_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_limit_q;
    logic              r_reload_q;
    logic [PASS_W-1:0] r_passes;
    logic              r_done;
    logic              r_busy;

    logic [WIDTH-1:0]  w_count;
    logic              w_clr;
    logic              w_en;
    logic              w_accept;
    logic              w_terminal;
    logic              w_at_limit;

    assign w_at_limit = (w_count == r_limit_q);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_accept    = 1'b0;
        w_terminal  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                end else if (bus.start) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                end else if (bus.pause) begin
                    w_state_nxt = HOLD;
                end else if (w_at_limit) begin
                    w_terminal = 1'b1;
                    // Reload restarts from 0 on the same edge; single-shot parks at limit.
                    if (r_reload_q)
                        w_clr = 1'b1;
                    else
                        w_state_nxt = DONE;
                end else begin
                    w_en = 1'b1;
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                end else if (!bus.pause) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_limit_q  <= '0;
            r_reload_q <= 1'b0;
            r_passes   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_terminal;
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == HOLD);
            if (w_accept) begin
                r_limit_q  <= bus.limit;
                r_reload_q <= bus.reload;
                r_passes   <= '0;
            end else if (w_terminal && (r_passes != '1)) begin
                r_passes <= r_passes + PASS_W'(1);
            end
        end
    end

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count)
    );

    assign bus.count  = w_count;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.passes = r_passes;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: single-shot, reload, pause, abort, saturation, reset.
module tb_counter_ctrl;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    counter_ctrl_if #(.WIDTH(2), .PASS_W(8)) bus ();

    counter_ctrl #(.WIDTH(2), .PASS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] c, input logic b,
                           input logic d, input logic [31:0] p);
        chk({tag, ".count"},  32'(bus.count),  c);
        chk({tag, ".busy"},   32'(bus.busy),   32'(b));
        chk({tag, ".done"},   32'(bus.done),   32'(d));
        chk({tag, ".passes"}, 32'(bus.passes), p);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.limit  = '0;
        bus.reload = 1'b0;
        bus.pause  = 1'b0;
        bus.abort  = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0);

        // Single-shot run to the top legal value
        bus.limit = 2'd3; bus.reload = 1'b0; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("ss_k0", 0, 1, 0, 0);
        step(); chk_all("ss_k1", 1, 1, 0, 0);
        step(); chk_all("ss_k2", 2, 1, 0, 0);
        step(); chk_all("ss_k3", 3, 1, 0, 0);
        step(); chk_all("ss_term", 3, 0, 1, 1);
        step(); chk_all("ss_hold", 3, 0, 0, 1);

        // Reload mode, limit 2: pass length 3
        bus.limit = 2'd2; bus.reload = 1'b1; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("rl_k0", 0, 1, 0, 0);
        for (int n = 1; n <= 9; n++) begin
            step();
            chk_all("rl_loop", 32'(n % 3), 1, (n % 3) == 0, 32'(n / 3));
        end
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        chk_all("rl_abort", 0, 0, 0, 3);

        // Pause for two cycles at count 1
        bus.limit = 2'd3; bus.reload = 1'b0; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("pz_k0", 0, 1, 0, 0);
        step(); chk_all("pz_k1", 1, 1, 0, 0);
        bus.pause = 1'b1;
        step(); chk_all("pz_hold1", 1, 1, 0, 0);
        step(); chk_all("pz_hold2", 1, 1, 0, 0);
        bus.pause = 1'b0;
        step(); chk_all("pz_resume", 1, 1, 0, 0);
        step(); chk_all("pz_c2", 2, 1, 0, 0);
        step(); chk_all("pz_c3", 3, 1, 0, 0);
        step(); chk_all("pz_done", 3, 0, 1, 1);

        // Abort mid-run, then start+abort together in IDLE
        bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("ab_k0", 0, 1, 0, 0);
        step(); chk_all("ab_k1", 1, 1, 0, 0);
        step(); chk_all("ab_k2", 2, 1, 0, 0);
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        chk_all("ab_now", 0, 0, 0, 0);
        step(); chk_all("ab_idle", 0, 0, 0, 0);
        bus.start = 1'b1; bus.abort = 1'b1;
        step(); bus.start = 1'b0; bus.abort = 1'b0;
        chk_all("ab_both", 0, 0, 0, 0);
        step(); chk_all("ab_both2", 0, 0, 0, 0);

        // limit 0 in reload mode: done every cycle, passes saturate
        bus.limit = 2'd0; bus.reload = 1'b1; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("z_k0", 0, 1, 0, 0);
        for (int n = 1; n <= 300; n++) begin
            step();
            chk("z_done", 32'(bus.done), 1);
            chk("z_passes", 32'(bus.passes), (n < 255) ? 32'(n) : 32'd255);
        end
        chk_all("z_sat", 0, 1, 1, 255);
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        chk_all("z_abort", 0, 0, 0, 255);

        // Start during RUN with a different limit is ignored
        bus.limit = 2'd3; bus.reload = 1'b0; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("ig_k0", 0, 1, 0, 0);
        bus.limit = 2'd1; bus.reload = 1'b1; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("ig_k1", 1, 1, 0, 0);
        step(); chk_all("ig_k2", 2, 1, 0, 0);
        step(); chk_all("ig_k3", 3, 1, 0, 0);
        step(); chk_all("ig_done", 3, 0, 1, 1);

        // Reset in RUN at count 2
        bus.limit = 2'd3; bus.reload = 1'b0; bus.start = 1'b1;
        step(); bus.start = 1'b0;
        chk_all("rs_k0", 0, 1, 0, 0);
        step(); chk_all("rs_k1", 1, 1, 0, 0);
        step(); chk_all("rs_k2", 2, 1, 0, 0);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk_all("rs_now", 0, 0, 0, 0);
        step(); chk_all("rs_idle", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
